// File: rtl/seq_ctrl_if.sv
// Data-memory request bus between the sequencer and data memory.
// The sequencer holds mem_req until memory answers with mem_ready.
interface seq_ctrl_if;
  logic mem_req;
  logic mem_wr;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_wr,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_wr,
    output mem_ready
  );
endinterface

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer: PC, IR/RF/memory strobes, branches,
// halt/restart, memory-wait watchdog and retired-instruction count.
module seq_ctrl #(
  parameter logic [3:0]  OP_LD    = 4'h8,
  parameter logic [3:0]  OP_ST    = 4'h9,
  parameter logic [3:0]  OP_HLT   = 4'h7,
  parameter logic [3:0]  OP_JMP   = 4'hD,
  parameter logic [3:0]  OP_BRZ   = 4'hE,
  parameter logic [3:0]  OP_BRN   = 4'hF,
  parameter int unsigned MAX_WAIT = 8,
  parameter logic [15:0] CNT_MAX  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [7:0]  bamt,
  input  logic        z,
  input  logic        neg,
  seq_ctrl_if.master  mem,
  output logic [15:0] PC,
  output logic        ir_we,
  output logic        rf_we,
  output logic        done,
  output logic        err,
  output logic [15:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEMWAIT,
    S_HALT
  } state_t;

  localparam logic [7:0] WLAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_d;
  logic        done_d, err_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [15:0] cnt_d;
  logic        retire, clr_cnt;

  logic is_ld, is_st, is_hlt, is_br, taken;
  logic [15:0] pc_inc, pc_br;

  assign is_ld  = (op == OP_LD);
  assign is_st  = (op == OP_ST);
  assign is_hlt = (op == OP_HLT);
  assign is_br  = (op == OP_JMP) || (op == OP_BRZ) || (op == OP_BRN);
  assign taken  = ((op == OP_BRZ) && z) ||
                  ((op == OP_BRN) && neg) ||
                  (op == OP_JMP);
  assign pc_inc = PC + 16'd1;
  assign pc_br  = PC + {{8{bamt[7]}}, bamt};

  always_comb begin
    state_d     = state_q;
    pc_d        = PC;
    done_d      = done;
    err_d       = err;
    wcnt_d      = wcnt_q;
    retire      = 1'b0;
    clr_cnt     = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_wr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = 16'd0;
        end
      end
      S_FETCH: begin
        ir_we   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_hlt: begin
            state_d = S_HALT;
            done_d  = 1'b1;
            retire  = 1'b1;
          end
          is_ld, is_st: begin
            mem.mem_req = 1'b1;
            mem.mem_wr  = is_st;
            wcnt_d      = 8'd0;
            state_d     = S_MEMWAIT;
          end
          is_br: begin
            pc_d    = taken ? pc_br : pc_inc;
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: begin
            rf_we   = 1'b1;
            pc_d    = pc_inc;
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEMWAIT: begin
        mem.mem_req = 1'b1;
        mem.mem_wr  = is_st;
        if (mem.mem_ready) begin
          rf_we   = is_ld;
          pc_d    = pc_inc;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (wcnt_q == WLAST) begin
          // watchdog: abandon the request without retiring it
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = 16'd0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wcnt_d  = 8'd0;
          clr_cnt = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = instr_cnt;
    if (clr_cnt)
      cnt_d = 16'd0;
    else if (retire && (instr_cnt != CNT_MAX))
      cnt_d = instr_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      PC        <= 16'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      wcnt_q    <= 8'd0;
      instr_cnt <= 16'd0;
    end else begin
      state_q   <= state_d;
      PC        <= pc_d;
      done      <= done_d;
      err       <= err_d;
      wcnt_q    <= wcnt_d;
      instr_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: instruction walk, branches, memory
// handshake, watchdog, reset/start corner cases and count saturation.
module tb_seq_ctrl;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] LD  = 4'h8;
  localparam logic [3:0] ST  = 4'h9;
  localparam logic [3:0] HLT = 4'h7;
  localparam logic [3:0] JMP = 4'hD;
  localparam logic [3:0] BRZ = 4'hE;
  localparam logic [3:0] BRN = 4'hF;
  localparam logic [15:0] SAT = 16'h000A;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [7:0]  bamt;
  logic        z;
  logic        neg;
  logic [15:0] PC;
  logic        ir_we, rf_we, done, err;
  logic [15:0] instr_cnt;

  int total = 0;
  int fails = 0;

  seq_ctrl_if mif ();

  seq_ctrl #(.CNT_MAX(SAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .bamt      (bamt),
    .z         (z),
    .neg       (neg),
    .mem       (mif.master),
    .PC        (PC),
    .ir_we     (ir_we),
    .rf_we     (rf_we),
    .done      (done),
    .err       (err),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n clock edges, land 2 time units past the last edge
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // from FETCH: run one non-memory instruction back to FETCH
  task automatic run(logic [3:0] o, logic [7:0] b);
    op   = o;
    bamt = b;
    cyc(2);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = ADD;
    bamt  = 8'h00;
    z     = 1'b0;
    neg   = 1'b0;
    mif.mem_ready = 1'b0;
    cyc(2);
    reset = 1'b0;
    #1;
    chk("rst_pc", PC, 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_cnt", instr_cnt, 16'h0);
    chk("rst_irwe", 16'(ir_we), 16'h0);
    chk("rst_req", 16'(mif.mem_req), 16'h0);

    // ADD, ADD, HLT
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    #1;
    chk("f0_irwe", 16'(ir_we), 16'h1);
    chk("f0_pc", PC, 16'h0);
    op = ADD;
    cyc(1); #1;
    chk("e0_rfwe", 16'(rf_we), 16'h1);
    chk("e0_irwe", 16'(ir_we), 16'h0);
    cyc(1); #1;
    chk("f1_irwe", 16'(ir_we), 16'h1);
    chk("f1_pc", PC, 16'h1);
    cyc(1); #1;
    chk("e1_rfwe", 16'(rf_we), 16'h1);
    cyc(1); #1;
    chk("f2_pc", PC, 16'h2);
    op = HLT;
    cyc(1); #1;
    chk("hlt_rfwe", 16'(rf_we), 16'h0);
    cyc(1); #1;
    chk("hlt_done", 16'(done), 16'h1);
    chk("hlt_cnt", instr_cnt, 16'h3);
    chk("hlt_pc", PC, 16'h2);
    cyc(2); #1;
    chk("hlt_pc_frz", PC, 16'h2);
    chk("hlt_irwe", 16'(ir_we), 16'h0);

    // restart, branches
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    #1;
    chk("rs_pc", PC, 16'h0);
    chk("rs_done", 16'(done), 16'h0);
    chk("rs_cnt", instr_cnt, 16'h0);
    run(JMP, 8'h05); #1;
    chk("jmp5_pc", PC, 16'h5);
    z = 1'b1;
    run(BRZ, 8'hFD); #1;
    chk("brz_t_pc", PC, 16'h2);
    z = 1'b0;
    run(JMP, 8'h03); #1;
    chk("jmp3_pc", PC, 16'h5);
    neg = 1'b1;
    run(BRZ, 8'hFD); #1;
    chk("brz_nt_pc", PC, 16'h6);
    neg = 1'b0;
    run(JMP, 8'hF8); #1;
    chk("jmp_neg_pc", PC, 16'hFFFE);
    run(JMP, 8'h04); #1;
    chk("jmp_wrap_pc", PC, 16'h0002);
    chk("br_cnt", instr_cnt, 16'h6);

    // LD, ready on the second MEMWAIT cycle
    op = LD;
    cyc(1); #1;
    chk("ld_e_req", 16'(mif.mem_req), 16'h1);
    chk("ld_e_wr", 16'(mif.mem_wr), 16'h0);
    chk("ld_e_rfwe", 16'(rf_we), 16'h0);
    cyc(1); #1;
    chk("ld_w1_req", 16'(mif.mem_req), 16'h1);
    chk("ld_w1_rfwe", 16'(rf_we), 16'h0);
    cyc(1);
    mif.mem_ready = 1'b1;
    #1;
    chk("ld_w2_req", 16'(mif.mem_req), 16'h1);
    chk("ld_w2_rfwe", 16'(rf_we), 16'h1);
    cyc(1);
    mif.mem_ready = 1'b0;
    #1;
    chk("ld_f_req", 16'(mif.mem_req), 16'h0);
    chk("ld_pc", PC, 16'h3);
    chk("ld_cnt", instr_cnt, 16'h7);

    // ST, same timing
    op = ST;
    cyc(1); #1;
    chk("st_e_wr", 16'(mif.mem_wr), 16'h1);
    cyc(1); #1;
    chk("st_w1_wr", 16'(mif.mem_wr), 16'h1);
    cyc(1);
    mif.mem_ready = 1'b1;
    #1;
    chk("st_w2_wr", 16'(mif.mem_wr), 16'h1);
    chk("st_w2_rfwe", 16'(rf_we), 16'h0);
    cyc(1);
    mif.mem_ready = 1'b0;
    #1;
    chk("st_pc", PC, 16'h4);
    chk("st_cnt", instr_cnt, 16'h8);

    // LD timeout
    op = LD;
    cyc(2); #1;
    chk("to_w1_req", 16'(mif.mem_req), 16'h1);
    cyc(7); #1;
    chk("to_w8_req", 16'(mif.mem_req), 16'h1);
    chk("to_w8_err", 16'(err), 16'h0);
    cyc(1); #1;
    chk("to_err", 16'(err), 16'h1);
    chk("to_done", 16'(done), 16'h1);
    chk("to_req", 16'(mif.mem_req), 16'h0);
    chk("to_cnt", instr_cnt, 16'h8);
    chk("to_pc", PC, 16'h4);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    #1;
    chk("to_rs_pc", PC, 16'h0);
    chk("to_rs_err", 16'(err), 16'h0);
    chk("to_rs_done", 16'(done), 16'h0);
    chk("to_rs_cnt", instr_cnt, 16'h0);

    // start ignored in FETCH and EXEC
    op = ADD;
    start = 1'b1;
    cyc(1); #1;
    chk("ign_f_irwe", 16'(ir_we), 16'h0);
    chk("ign_f_pc", PC, 16'h0);
    cyc(1); #1;
    chk("ign_e_pc", PC, 16'h1);
    chk("ign_e_irwe", 16'(ir_we), 16'h1);
    start = 1'b0;

    // reset with start during MEMWAIT
    op = LD;
    cyc(2); #1;
    chk("rm_req_pre", 16'(mif.mem_req), 16'h1);
    reset = 1'b1;
    start = 1'b1;
    cyc(1);
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("rm_req", 16'(mif.mem_req), 16'h0);
    chk("rm_pc", PC, 16'h0);
    chk("rm_cnt", instr_cnt, 16'h0);
    chk("rm_done", 16'(done), 16'h0);
    cyc(1); #1;
    chk("rm_idle", 16'(ir_we), 16'h0);

    // ADD / JMP -1 loop up to saturation
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run(ADD, 8'h00);
      run(JMP, 8'hFF);
    end
    #1;
    chk("sat_mid", instr_cnt, 16'h8);
    chk("sat_pc", PC, 16'h0);
    for (int i = 0; i < 3; i++) begin
      run(ADD, 8'h00);
      run(JMP, 8'hFF);
    end
    #1;
    chk("sat_hold", instr_cnt, SAT);
    op = HLT;
    cyc(2); #1;
    chk("sat_hlt", instr_cnt, SAT);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
Multi-cycle sequencer for the single-issue core. It owns the program counter and drives the per-instruction strobes: instruction-register capture, register-file write and data-memory request. It walks each instruction through FETCH, EXEC and an optional MEMWAIT, and resolves branches from the ALU flags. It also handles start/halt, a memory-wait watchdog and a retired-instruction counter.

Parameters:
OP_LD, 4'h8, load opcode (memory read, writes register file)
OP_ST, 4'h9, store opcode (memory write, no register-file write)
OP_HLT, 4'h7, halt opcode
OP_JMP, 4'hD, unconditional relative jump
OP_BRZ, 4'hE, relative branch if z
OP_BRN, 4'hF, relative branch if neg
MAX_WAIT, 8, maximum MEMWAIT cycles before error (1..255)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; overrides all other inputs
start  in  1  begin execution at PC=0; honoured only in IDLE or HALT
op  in  4  opcode from instruction register; valid in EXEC
bamt  in  8  signed branch offset from instruction register; valid in EXEC
z  in  1  ALU zero flag; sampled in EXEC only
neg  in  1  ALU negative flag; sampled in EXEC only
mem_ready  in  1  data memory completes the current request
PC  out  16  program counter (registered)
ir_we  out  1  capture imem[PC] into instruction register
rf_we  out  1  register-file write enable
mem_req  out  1  data-memory request, held until completion
mem_wr  out  1  qualifies mem_req as a store
done  out  1  processor halted (registered)
err  out  1  memory-wait timeout occurred (registered, sticky until restart)
instr_cnt  out  16  retired-instruction count (registered, saturating)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, PC=0, done=0, err=0, instr_cnt=0, wait counter=0. All strobes are 0 because they decode from IDLE.
- Strobes are combinational decodes of state and op. PC, state, done, err and instr_cnt are registered.
- States: IDLE, FETCH, EXEC, MEMWAIT, HALT.
- IDLE: all strobes 0, PC held. start=1 -> FETCH with PC=0.
- FETCH: ir_we=1 for exactly one cycle -> EXEC. PC held.
- EXEC, op==OP_HLT: -> HALT, done=1 from the next cycle. PC held. Instruction retires.
- EXEC, op==OP_LD or OP_ST: mem_req=1 combinationally; mem_wr=1 for ST. Wait counter cleared. -> MEMWAIT.
- EXEC, branch ops: taken = (OP_BRZ & z) | (OP_BRN & neg) | OP_JMP.
  - Taken: PC <= PC + sign-extend16(bamt), modulo 2^16 (wraps both ways).
  - Not taken: PC <= PC+1. rf_we=0. -> FETCH.
- EXEC, any other op: rf_we=1, PC <= PC+1, -> FETCH.
- MEMWAIT: mem_req=1, and mem_wr=1 if op==OP_ST; op is held stable by the IR.
  - mem_ready=1: rf_we=1 if LD, PC <= PC+1, -> FETCH.
  - Else the wait counter increments. When it reaches MAX_WAIT without mem_ready: err<=1, done<=1, -> HALT, PC held, instruction not retired.
- Latency: non-memory instruction is 2 cycles. Memory instruction is 3 cycles minimum (mem_ready in the first MEMWAIT cycle) plus 1 per extra wait cycle.
- instr_cnt increments by 1 on each retire (EXEC->FETCH, EXEC->HALT, MEMWAIT->FETCH) and saturates at 16'hFFFF.
- HALT: strobes 0, done=1, PC and instr_cnt frozen.
  - start=1 -> FETCH with PC=0; done, err, instr_cnt and wait counter cleared.
- start outside IDLE/HALT is ignored.
- mem_ready outside MEMWAIT is ignored.
- reset with start in the same cycle: reset wins, state is IDLE.
- reset mid-MEMWAIT: IDLE next cycle and mem_req drops. The abandoned request is not retired.
- bamt=0 on a taken branch: PC unchanged, so an infinite loop is legal.
- z/neg values in cycles other than EXEC have no effect.

Test Plan:
- Reset, start, ops {ADD 4'h1, ADD, HLT}: ir_we pulses every 2 cycles; PC goes 0,1,2; rf_we high in the two ADD EXEC cycles; done=1 and instr_cnt=3 after HLT; PC stays 2.
- PC=5, BRZ bamt=-3 (8'hFD), z=1: PC=2. Same with z=0: PC=6. JMP bamt=+4 at PC=16'hFFFE: PC=16'h0002 (wrap).
- LD with mem_ready asserted 2 cycles after MEMWAIT entry: mem_req high for 3 cycles; rf_we pulses only in the ready cycle; PC+1; instr_cnt+1. ST in the same setup: mem_wr=1 throughout and rf_we never set.
- LD with mem_ready held 0: after MAX_WAIT=8 MEMWAIT cycles, err=1, done=1, mem_req=0, instr_cnt unchanged. Then start: PC=0, err=0, done=0, instr_cnt=0.
- Reset asserted during MEMWAIT together with start: next cycle state IDLE, all outputs at reset values, mem_req=0. start during FETCH or EXEC is ignored, with no PC change.
- Preload instr_cnt near saturation via a long ADD loop, using JMP bamt=-1 back to ADD: count reaches 16'hFFFF and holds.
